// File: rtl/overlay_update_ctrl_pkg.sv
// Shared constants and types for the overlay text-RAM update controller.
// The text RAM address width is also used by the compositor read side.
package overlay_update_ctrl_pkg;

  localparam int TEXT_DEPTH = 80;
  localparam int ADDR_W     = 7;
  localparam int FIFO_DEPTH = 16;
  localparam int ENTRY_W    = ADDR_W + 8;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [9:0]        Y_ACTIVE     = 10'd720;
  localparam logic [7:0]        CLEAR_CHAR   = 8'h20;
  localparam logic              RST_EN_IMAGE = 1'b1;
  localparam logic              RST_EN_TEXT  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(TEXT_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr <= LAST_ADDR);
  endfunction

endpackage

// File: rtl/overlay_update_ctrl_if.sv
// Host-side request channel: character writes, clear request and enable config.
interface overlay_update_ctrl_if;
  import overlay_update_ctrl_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;
  logic              clr_req;
  logic              cfg_valid;
  logic              cfg_en_image;
  logic              cfg_en_text;

  modport master (
    output wr_valid, wr_addr, wr_char, clr_req, cfg_valid, cfg_en_image, cfg_en_text,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_char, clr_req, cfg_valid, cfg_en_image, cfg_en_text,
    output wr_ready
  );

endinterface

// File: rtl/overlay_update_ctrl_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output from the storage registers.
// A push is accepted while full only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 16
) (
  input  logic                       pixel_clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign level     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array write
  always_ff @(posedge pixel_clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/overlay_update_ctrl.sv
// Sole writer of the text character RAM: queues host updates and applies clears,
// queued writes and enable changes only during vertical blanking.
module overlay_update_ctrl
  import overlay_update_ctrl_pkg::*;
(
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic [9:0]           y_coord,
  overlay_update_ctrl_if.slave host,
  output logic                 tram_we,
  output logic [ADDR_W-1:0]    tram_addr,
  output logic [7:0]           tram_wdata,
  output logic                 enable_image,
  output logic                 enable_text,
  output logic                 busy,
  output logic                 err_addr,
  output logic [15:0]          frame_cnt
);

  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               at_active_r;
  logic               vblank_start_s;
  logic               in_vblank_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic               clr_wr_s;
  logic               clr_done_s;
  logic               clr_pending_r;
  logic [ADDR_W-1:0]  clr_addr_r;
  logic               shadow_image_r;
  logic               shadow_text_r;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [LVL_W-1:0]   fifo_level_s;
  logic [ENTRY_W-1:0] fifo_dout_s;

  assign vblank_start_s = (y_coord == Y_ACTIVE) && !at_active_r;
  assign in_vblank_s    = (y_coord >= Y_ACTIVE);
  assign host.wr_ready  = !fifo_full_s;
  assign accept_s       = host.wr_valid && host.wr_ready;
  // Out-of-range writes still complete the handshake but never reach the queue.
  assign push_s         = accept_s && addr_in_range(host.wr_addr);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .push      (push_s),
    .din       ({host.wr_addr, host.wr_char}),
    .pop       (pop_s),
    .dout      (fifo_dout_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s)
  );

  // Next-state and per-cycle write selection
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    clr_wr_s    = 1'b0;
    clr_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (vblank_start_s) begin
          if (clr_pending_r) begin
            state_nxt_s = ST_CLEAR;
          end else if (!fifo_empty_s) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (!in_vblank_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          clr_wr_s = 1'b1;
          if (clr_addr_r == LAST_ADDR) begin
            clr_done_s  = 1'b1;
            state_nxt_s = fifo_empty_s ? ST_WAIT : ST_DRAIN;
          end else begin
            state_nxt_s = ST_CLEAR;
          end
        end
      end
      ST_DRAIN: begin
        if (!in_vblank_s) begin
          state_nxt_s = ST_IDLE;
        end else if (fifo_empty_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          pop_s = 1'b1;
          // Leave as soon as the last entry goes, so busy covers only writing cycles.
          if ((fifo_level_s == LVL_ONE) && !push_s) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
      end
      ST_WAIT: begin
        if (!in_vblank_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register, blanking edge detect and busy flag
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      at_active_r <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      at_active_r <= (y_coord == Y_ACTIVE);
      busy        <= (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_DRAIN);
    end
  end

  // Registered text RAM write port
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      tram_we    <= 1'b0;
      tram_addr  <= '0;
      tram_wdata <= 8'h00;
    end else begin
      tram_we    <= clr_wr_s || pop_s;
      tram_addr  <= clr_wr_s ? clr_addr_r : fifo_dout_s[ENTRY_W-1:8];
      tram_wdata <= clr_wr_s ? CLEAR_CHAR : fifo_dout_s[7:0];
    end
  end

  // Clear sweep address and pending flag; an interrupted sweep restarts at 0
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      clr_addr_r    <= '0;
      clr_pending_r <= 1'b0;
    end else begin
      if (clr_wr_s && !clr_done_s) begin
        clr_addr_r <= clr_addr_r + 1'b1;
      end else begin
        clr_addr_r <= '0;
      end
      if (host.clr_req) begin
        clr_pending_r <= 1'b1;
      end else if (clr_done_s) begin
        clr_pending_r <= 1'b0;
      end else begin
        clr_pending_r <= clr_pending_r;
      end
    end
  end

  // Enable shadow, frame-synchronous enables, frame counter and address error
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      shadow_image_r <= RST_EN_IMAGE;
      shadow_text_r  <= RST_EN_TEXT;
      enable_image   <= RST_EN_IMAGE;
      enable_text    <= RST_EN_TEXT;
      frame_cnt      <= 16'd0;
      err_addr       <= 1'b0;
    end else begin
      if (host.cfg_valid) begin
        shadow_image_r <= host.cfg_en_image;
        shadow_text_r  <= host.cfg_en_text;
      end
      if (vblank_start_s) begin
        enable_image <= shadow_image_r;
        enable_text  <= shadow_text_r;
        frame_cnt    <= frame_cnt + 16'd1;
      end
      if (accept_s && !addr_in_range(host.wr_addr)) begin
        err_addr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_overlay_update_ctrl.sv
// Directed bench for overlay_update_ctrl: observes the text RAM write port and
// checks every write, enable and status output against hand-computed values.
module tb_overlay_update_ctrl;
  import overlay_update_ctrl_pkg::*;

  logic              pixel_clk = 1'b0;
  logic              rst;
  logic [9:0]        y_coord;
  logic              tram_we;
  logic [ADDR_W-1:0] tram_addr;
  logic [7:0]        tram_wdata;
  logic              enable_image;
  logic              enable_text;
  logic              busy;
  logic              err_addr;
  logic [15:0]       frame_cnt;

  overlay_update_ctrl_if hif ();

  overlay_update_ctrl dut (
    .pixel_clk    (pixel_clk),
    .rst          (rst),
    .y_coord      (y_coord),
    .host         (hif),
    .tram_we      (tram_we),
    .tram_addr    (tram_addr),
    .tram_wdata   (tram_wdata),
    .enable_image (enable_image),
    .enable_text  (enable_text),
    .busy         (busy),
    .err_addr     (err_addr),
    .frame_cnt    (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;
  logic [ENTRY_W-1:0] wlog[$];
  int busy_cnt = 0;
  int exp_frames = 0;

  // Record every text RAM write and every busy cycle, sampled mid-cycle
  always @(negedge pixel_clk) begin
    if (tram_we) wlog.push_back({tram_addr, tram_wdata});
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pixel_clk);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [7:0] c);
    int waited = 0;
    hif.wr_valid = 1'b1;
    hif.wr_addr  = a;
    hif.wr_char  = c;
    while (!hif.wr_ready && waited < 200) begin
      step(1);
      waited++;
    end
    chk("wr_handshake_bound", 32'(waited < 200), 32'd1);
    step(1);
    hif.wr_valid = 1'b0;
  endtask

  task automatic vblank(input int n);
    y_coord = Y_ACTIVE;
    step(n);
    y_coord = 10'd0;
    step(2);
    exp_frames++;
  endtask

  initial begin
    int waited;
    int bad;
    int n;
    logic [ENTRY_W-1:0] e;

    rst = 1'b1;
    y_coord = 10'd0;
    hif.wr_valid = 1'b0;
    hif.wr_addr = '0;
    hif.wr_char = 8'h00;
    hif.clr_req = 1'b0;
    hif.cfg_valid = 1'b0;
    hif.cfg_en_image = 1'b0;
    hif.cfg_en_text = 1'b0;
    step(3);
    chk("rst_tram_we", 32'(tram_we), 32'd0);
    chk("rst_en_image", 32'(enable_image), 32'd1);
    chk("rst_en_text", 32'(enable_text), 32'd1);
    chk("rst_wr_ready", 32'(hif.wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;

    // Single write is held until blanking
    y_coord = 10'd100;
    step(2);
    host_write(7'd5, 8'h41);
    step(5);
    chk("t1_no_write_active", wlog.size(), 32'd0);
    y_coord = Y_ACTIVE;
    step(2);
    chk("t1_we", 32'(tram_we), 32'd1);
    chk("t1_addr", 32'(tram_addr), 32'd5);
    chk("t1_data", 32'(tram_wdata), 32'h41);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    step(1);
    chk("t1_we_once", 32'(tram_we), 32'd0);
    step(20);
    chk("t1_write_count", wlog.size(), 32'd1);
    y_coord = 10'd0;
    step(2);
    exp_frames = 1;

    // Fill the queue, then a 17th write waits for the first drain pop
    wlog.delete();
    y_coord = 10'd100;
    for (int i = 0; i < 16; i++) host_write(7'(10 + i), 8'(8'h30 + i));
    chk("t2_full_ready", 32'(hif.wr_ready), 32'd0);
    hif.wr_valid = 1'b1;
    hif.wr_addr = 7'd26;
    hif.wr_char = 8'h40;
    step(3);
    chk("t2_held_ready", 32'(hif.wr_ready), 32'd0);
    y_coord = Y_ACTIVE;
    waited = 0;
    while (!hif.wr_ready && waited < 50) begin
      step(1);
      waited++;
    end
    chk("t2_ready_after_pop", 32'(waited), 32'd2);
    step(1);
    hif.wr_valid = 1'b0;
    step(25);
    y_coord = 10'd0;
    step(2);
    exp_frames++;
    chk("t2_write_count", wlog.size(), 32'd17);
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      e = (i < wlog.size()) ? wlog[i] : '0;
      if (e !== {7'(10 + i), 8'(8'h30 + i)}) bad++;
    end
    chk("t2_order", 32'(bad), 32'd0);

    // Clear precedes a write queued after the clear request
    wlog.delete();
    hif.clr_req = 1'b1;
    step(1);
    hif.clr_req = 1'b0;
    host_write(7'd3, 8'h5A);
    busy_cnt = 0;
    vblank(100);
    chk("t3_write_count", wlog.size(), 32'd81);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      e = (i < wlog.size()) ? wlog[i] : '0;
      if (e !== {7'(i), 8'h20}) bad++;
    end
    chk("t3_clear_sweep", 32'(bad), 32'd0);
    e = (wlog.size() > 80) ? wlog[80] : '0;
    chk("t3_after_clear", 32'(e), 32'({7'd3, 8'h5A}));
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd81);

    // Out-of-range address is accepted and flagged, never written
    wlog.delete();
    host_write(7'd85, 8'h78);
    chk("t4_err_addr", 32'(err_addr), 32'd1);
    chk("t4_ready", 32'(hif.wr_ready), 32'd1);
    vblank(20);
    chk("t4_no_write", wlog.size(), 32'd0);

    // Enable change is frame synchronous
    y_coord = 10'd300;
    step(2);
    hif.cfg_en_image = 1'b0;
    hif.cfg_en_text = 1'b1;
    hif.cfg_valid = 1'b1;
    step(1);
    hif.cfg_valid = 1'b0;
    step(3);
    chk("t5_image_held", 32'(enable_image), 32'd1);
    chk("t5_text_held", 32'(enable_text), 32'd1);
    y_coord = Y_ACTIVE;
    #1;
    chk("t5_image_edge", 32'(enable_image), 32'd1);
    step(1);
    exp_frames++;
    chk("t5_image_new", 32'(enable_image), 32'd0);
    chk("t5_text_new", 32'(enable_text), 32'd1);
    chk("t5_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    step(5);
    y_coord = 10'd0;
    step(2);

    // Clear interrupted by end of blanking restarts from address 0
    wlog.delete();
    hif.clr_req = 1'b1;
    step(1);
    hif.clr_req = 1'b0;
    y_coord = Y_ACTIVE;
    waited = 0;
    while (wlog.size() < 40 && waited < 200) begin
      step(1);
      waited++;
    end
    y_coord = 10'd0;
    exp_frames++;
    step(1);
    n = wlog.size();
    step(10);
    // 40 seen plus the one already on the registered port when blanking ended
    chk("t6_abort_count", 32'(n), 32'd41);
    chk("t6_stopped", wlog.size(), 32'(n));
    chk("t6_busy_low", 32'(busy), 32'd0);
    wlog.delete();
    vblank(100);
    chk("t6_restart_count", wlog.size(), 32'd80);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      e = (i < wlog.size()) ? wlog[i] : '0;
      if (e !== {7'(i), 8'h20}) bad++;
    end
    chk("t6_restart_sweep", 32'(bad), 32'd0);
    vblank(20);
    chk("t6_clear_done", wlog.size(), 32'd80);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Reset during drain discards the queue
    y_coord = 10'd100;
    for (int i = 0; i < 5; i++) host_write(7'(50 + i), 8'(8'h61 + i));
    y_coord = Y_ACTIVE;
    waited = 0;
    while (!tram_we && waited < 20) begin
      step(1);
      waited++;
    end
    chk("t7_drain_started", 32'(tram_we), 32'd1);
    chk("t7_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t7_we_reset", 32'(tram_we), 32'd0);
    chk("t7_busy_reset", 32'(busy), 32'd0);
    chk("t7_ready_reset", 32'(hif.wr_ready), 32'd1);
    chk("t7_err_reset", 32'(err_addr), 32'd0);
    y_coord = 10'd0;
    step(2);
    rst = 1'b0;
    step(2);
    wlog.delete();
    exp_frames = 0;
    chk("t7_frame_cnt_reset", 32'(frame_cnt), 32'd0);
    vblank(20);
    chk("t7_no_writes", wlog.size(), 32'd0);
    chk("t7_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
